core_mem_arbiter: RTL

//  Shares one downstream memory port between the core's instruction (imem) and data (dmem) requesters.

---
 rtl/core_mem_arbiter.sv | 78 +++++++
 1 files changed

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one memory req/gnt port between imem and dmem, dmem priority, locked until granted.
// Define MEM_ARB_FAIR_EN to cap consecutive dmem grants at ARB_MAX_DMEM_RUN while imem waits.
module core_mem_arbiter #(
  parameter int unsigned MEM_ADDR_W       = 64,
  parameter int unsigned MEM_STRB_W       = 8,
  parameter int unsigned MEM_DATA_W       = 64,
  parameter int unsigned ARB_MAX_DMEM_RUN = 4
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  imem_req,
  input  logic                  imem_wen,
  input  logic [MEM_ADDR_W-1:0] imem_addr,
  input  logic [MEM_STRB_W-1:0] imem_strb,
  input  logic [MEM_DATA_W-1:0] imem_wdata,
  output logic                  imem_gnt,
  output logic                  imem_err,
  output logic [MEM_DATA_W-1:0] imem_rdata,
  input  logic                  dmem_req,
  input  logic                  dmem_wen,
  input  logic [MEM_ADDR_W-1:0] dmem_addr,
  input  logic [MEM_STRB_W-1:0] dmem_strb,
  input  logic [MEM_DATA_W-1:0] dmem_wdata,
  output logic                  dmem_gnt,
  output logic                  dmem_err,
  output logic [MEM_DATA_W-1:0] dmem_rdata,
  output logic                  mem_req,
  output logic                  mem_wen,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_STRB_W-1:0] mem_strb,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_err,
  input  logic [MEM_DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;
  state_t state, state_nxt;
  logic sel_i, sel_d, imem_first, rsp_i, rsp_d;
`ifdef MEM_ARB_FAIR_EN
  logic [3:0] run_cnt;
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) run_cnt <= '0;
    else if (imem_gnt || !imem_req) run_cnt <= '0;
    else if (dmem_gnt && run_cnt != 4'hf) run_cnt <= run_cnt + 4'd1;
  assign imem_first = imem_req && run_cnt == ARB_MAX_DMEM_RUN[3:0];
`else
  assign imem_first = 1'b0 & ARB_MAX_DMEM_RUN[0];
`endif
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) begin
      state <= IDLE;
      rsp_i <= 1'b0;
      rsp_d <= 1'b0;
    end else begin
      state <= state_nxt;
      rsp_i <= imem_gnt;
      rsp_d <= dmem_gnt;
    end
  // A held owner whose req vanishes yields mem_req = 0, which also sends the FSM back to IDLE.
  always_comb begin
    state_nxt = (mem_gnt || !mem_req) ? IDLE : sel_d ? HOLD_D : HOLD_I;
  end
  always_comb begin
    sel_d     = state == HOLD_D || (state == IDLE && dmem_req && !imem_first);
    sel_i     = state == HOLD_I || (state == IDLE && !sel_d && imem_req);
    mem_req   = sel_i ? imem_req : sel_d ? dmem_req : 1'b0;
    mem_wen   = mem_req && (sel_i ? imem_wen : dmem_wen);
    mem_addr  = !mem_req ? '0 : sel_i ? imem_addr : dmem_addr;
    mem_strb  = !mem_req ? '0 : sel_i ? imem_strb : dmem_strb;
    mem_wdata = !mem_req ? '0 : sel_i ? imem_wdata : dmem_wdata;
    imem_gnt  = mem_gnt && mem_req && sel_i;
    dmem_gnt  = mem_gnt && mem_req && sel_d;
  end
  assign imem_err   = rsp_i & mem_err;
  assign dmem_err   = rsp_d & mem_err;
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;
endmodule
